// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer.
//   state_t        : sequencer FSM states
//   Alu*           : alu_op encodings driven to the ALU
//   Op*            : bit positions of the one-hot decoder strobes in dec_op
//   is_onehot()    : true when exactly one decoder strobe is set
package cpu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StImm,
        StExec,
        StIo,
        StHalt
    } state_t;

    localparam logic [1:0] AluPass = 2'b00;
    localparam logic [1:0] AluAdd  = 2'b01;
    localparam logic [1:0] AluSub  = 2'b10;

    localparam int OpMova = 11;
    localparam int OpMovb = 10;
    localparam int OpMovc = 9;
    localparam int OpMovd = 8;
    localparam int OpAdd  = 7;
    localparam int OpSub  = 6;
    localparam int OpJmp  = 5;
    localparam int OpJg   = 4;
    localparam int OpIn1  = 3;
    localparam int OpOut1 = 2;
    localparam int OpMovi = 1;
    localparam int OpHalt = 0;

    function automatic logic is_onehot(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_wdog.sv
// Handshake watchdog for the sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (sequencer changed state)
//   en         : a wait cycle elapsed with no rdy/ack
//   expired    : this wait cycle is the WDOG_MAX-th in a row; never set when WDOG_MAX is 0
module cpu_seq_ctrl_wdog #(
    parameter int unsigned WDOG_MAX = 16,
    parameter int unsigned WDOG_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] Last = WDOG_W'(WDOG_MAX - 1);

    logic [WDOG_W-1:0] cnt_q;

    // Saturates at Last so a disabled watchdog cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != Last)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (WDOG_MAX != 0) && en && (cnt_q == Last);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 4-bit-opcode teaching CPU.
//   clk, rst_n         : clock, synchronous active-low reset
//   start              : leave IDLE and begin fetching
//   mem_rd / mem_rdy   : fetch request (held) / fetch data valid
//   ir_ld, imm_ld      : load IR / immediate register from memory data
//   pc_inc, pc_ld      : PC+1 / PC <= immediate
//   dec_en / dec_op    : decoder enable / one-hot decoder strobes
//   flag_gt            : ALU greater-than flag (jg condition)
//   reg_we, alu_op, flag_we, imm_sel : datapath write-back controls
//   in_en, out_en / io_ack : IO transfer requests (held) / transfer complete
//   busy, halted, err  : status; err is sticky until reset
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_MAX = 16,
    parameter int unsigned WDOG_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        mem_rd,
    input  logic        mem_rdy,
    output logic        ir_ld,
    output logic        imm_ld,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        dec_en,
    input  logic [11:0] dec_op,
    input  logic        flag_gt,
    output logic        reg_we,
    output logic [1:0]  alu_op,
    output logic        flag_we,
    output logic        imm_sel,
    output logic        in_en,
    output logic        out_en,
    input  logic        io_ack,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    state_t      state_q, state_d;
    logic [11:0] op_q, op_d;
    logic        err_q, err_d;
    logic        waiting, hs;
    logic        wdog_exp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Handshake that ends the current wait state.
    always_comb begin
        waiting = 1'b0;
        hs      = 1'b0;
        case (state_q)
            StFetch, StImm: begin
                waiting = 1'b1;
                hs      = mem_rdy;
            end
            StIo: begin
                waiting = 1'b1;
                hs      = io_ack;
            end
            default: ;
        endcase
    end

    cpu_seq_ctrl_wdog #(
        .WDOG_MAX (WDOG_MAX),
        .WDOG_W   (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_d != state_q),
        .en      (waiting && !hs),
        .expired (wdog_exp)
    );

    // Next state. wdog_exp is already masked by the handshake, so rdy/ack wins.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch, StImm: begin
                if (mem_rdy) begin
                    state_d = (state_q == StFetch) ? StDecode : StExec;
                end else if (wdog_exp) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StDecode: begin
                op_d = dec_op;
                if (!is_onehot(dec_op)) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end else if (dec_op[OpHalt]) begin
                    state_d = StHalt;
                end else if (dec_op[OpMovi] || dec_op[OpJmp] || dec_op[OpJg]) begin
                    state_d = StImm;
                end else if (dec_op[OpIn1] || dec_op[OpOut1]) begin
                    state_d = StIo;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: state_d = StFetch;
            StIo: begin
                if (io_ack) begin
                    state_d = StFetch;
                end else if (wdog_exp) begin
                    state_d = StHalt;
                    err_d   = 1'b1;
                end
            end
            StHalt:  ;
            default: state_d = StIdle;
        endcase
    end

    // Controls follow state and latched op; the load/write-back strobes are
    // additionally qualified by the handshake of the cycle they complete in,
    // and jg samples flag_gt during EXEC.
    always_comb begin
        mem_rd  = 1'b0;
        ir_ld   = 1'b0;
        imm_ld  = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        dec_en  = 1'b0;
        reg_we  = 1'b0;
        alu_op  = AluPass;
        flag_we = 1'b0;
        imm_sel = 1'b0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        case (state_q)
            StFetch: begin
                mem_rd = 1'b1;
                ir_ld  = mem_rdy;
                pc_inc = mem_rdy;
            end
            StDecode: dec_en = 1'b1;
            StImm: begin
                mem_rd = 1'b1;
                imm_ld = mem_rdy;
                pc_inc = mem_rdy;
            end
            StExec: begin
                if (op_q[OpMova] || op_q[OpMovb] || op_q[OpMovc] || op_q[OpMovd]) begin
                    reg_we = 1'b1;
                end
                if (op_q[OpAdd] || op_q[OpSub]) begin
                    reg_we  = 1'b1;
                    flag_we = 1'b1;
                    alu_op  = op_q[OpAdd] ? AluAdd : AluSub;
                end
                if (op_q[OpMovi]) begin
                    reg_we  = 1'b1;
                    imm_sel = 1'b1;
                end
                pc_ld = op_q[OpJmp] || (op_q[OpJg] && flag_gt);
            end
            StIo: begin
                in_en  = op_q[OpIn1];
                out_en = op_q[OpOut1];
                reg_we = op_q[OpIn1] && io_ack;
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != StIdle) && (state_q != StHalt);
    assign halted = (state_q == StHalt);
    assign err    = err_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: each scenario builds an expected cycle-by-cycle trace
// from instruction-level rules (phase lengths, wait counts, per-op controls),
// then drives it and compares every cycle.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, mem_rdy, io_ack, flag_gt;
    logic [11:0] dec_op;
    logic        mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, dec_en, reg_we;
    logic [1:0]  alu_op;
    logic        flag_we, imm_sel, in_en, out_en, busy, halted, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(
        .WDOG_MAX (16),
        .WDOG_W   (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mem_rd  (mem_rd),
        .mem_rdy (mem_rdy),
        .ir_ld   (ir_ld),
        .imm_ld  (imm_ld),
        .pc_inc  (pc_inc),
        .pc_ld   (pc_ld),
        .dec_en  (dec_en),
        .dec_op  (dec_op),
        .flag_gt (flag_gt),
        .reg_we  (reg_we),
        .alu_op  (alu_op),
        .flag_we (flag_we),
        .imm_sel (imm_sel),
        .in_en   (in_en),
        .out_en  (out_en),
        .io_ack  (io_ack),
        .busy    (busy),
        .halted  (halted),
        .err     (err)
    );

    localparam int WDOG = 16;

    // Output vector layout: {mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, dec_en, reg_we,
    //                        alu_op[1:0], flag_we, imm_sel, in_en, out_en, busy, halted, err}
    localparam logic [15:0] M_MEM_RD  = 16'h8000;
    localparam logic [15:0] M_IR_LD   = 16'h4000;
    localparam logic [15:0] M_IMM_LD  = 16'h2000;
    localparam logic [15:0] M_PC_INC  = 16'h1000;
    localparam logic [15:0] M_PC_LD   = 16'h0800;
    localparam logic [15:0] M_DEC_EN  = 16'h0400;
    localparam logic [15:0] M_REG_WE  = 16'h0200;
    localparam logic [15:0] M_ALU_SUB = 16'h0100;
    localparam logic [15:0] M_ALU_ADD = 16'h0080;
    localparam logic [15:0] M_FLAG_WE = 16'h0040;
    localparam logic [15:0] M_IMM_SEL = 16'h0020;
    localparam logic [15:0] M_IN_EN   = 16'h0010;
    localparam logic [15:0] M_OUT_EN  = 16'h0008;
    localparam logic [15:0] M_BUSY    = 16'h0004;
    localparam logic [15:0] M_HALTED  = 16'h0002;
    localparam logic [15:0] M_ERR     = 16'h0001;

    localparam int S_MOVA = 11, S_MOVB = 10, S_MOVC = 9, S_MOVD = 8, S_ADD = 7, S_SUB = 6;
    localparam int S_JMP = 5, S_JG = 4, S_IN1 = 3, S_OUT1 = 2, S_MOVI = 1, S_HALT = 0;

    typedef struct {
        logic        start;
        logic        mem_rdy;
        logic        io_ack;
        logic        flag_gt;
        logic [11:0] dec_op;
        logic [15:0] exp;
    } cyc_t;

    cyc_t q[$];
    bit   dead;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [11:0] stb(input int i);
        logic [11:0] v;
        v = 12'd1 << i;
        return v;
    endfunction

    function automatic logic [15:0] obs();
        return {mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, dec_en, reg_we, alu_op,
                flag_we, imm_sel, in_en, out_en, busy, halted, err};
    endfunction

    task automatic push(input logic [15:0] e, input logic rdy, input logic ack,
                        input logic gt, input logic [11:0] dop);
        cyc_t c;
        c.start   = rb();
        c.mem_rdy = rdy;
        c.io_ack  = ack;
        c.flag_gt = gt;
        c.dec_op  = dop;
        c.exp     = e;
        q.push_back(c);
    endtask

    task automatic push_start();
        push(16'h0000, rb(), rb(), rb(), 12'($urandom));
        q[q.size()-1].start = 1'b1;
    endtask

    // HALT persists and ignores start.
    task automatic model_halt(input logic with_err);
        for (int i = 0; i < 3; i++) begin
            push(M_HALTED | (with_err ? M_ERR : 16'h0), rb(), rb(), rb(), 12'($urandom));
            q[q.size()-1].start = 1'b1;
        end
        dead = 1'b1;
    endtask

    // A handshake phase: 'waits' idle cycles then the completing cycle,
    // unless the watchdog runs out first.
    task automatic model_wait(input int waits, input bit io, input logic [15:0] wexp,
                              input logic [15:0] dexp, output bit fired);
        fired = (waits >= WDOG);
        for (int i = 0; i < waits && i < WDOG; i++) begin
            if (io) push(wexp, rb(), 1'b0, rb(), 12'($urandom));
            else    push(wexp, 1'b0, rb(), rb(), 12'($urandom));
        end
        if (fired) model_halt(1'b1);
        else if (io) push(dexp, rb(), 1'b1, rb(), 12'($urandom));
        else push(dexp, 1'b1, rb(), rb(), 12'($urandom));
    endtask

    task automatic model_instr(input logic [11:0] s, input int fw, input int iw,
                               input int ow, input logic gt);
        bit          f;
        logic [15:0] e;
        if (dead) return;
        model_wait(fw, 1'b0, M_BUSY | M_MEM_RD, M_BUSY | M_MEM_RD | M_IR_LD | M_PC_INC, f);
        if (f) return;
        push(M_BUSY | M_DEC_EN, rb(), rb(), rb(), s);
        if ($countones(s) != 1) begin
            model_halt(1'b1);
            return;
        end
        if (s[S_HALT]) begin
            model_halt(1'b0);
            return;
        end
        if (s[S_MOVI] || s[S_JMP] || s[S_JG]) begin
            model_wait(iw, 1'b0, M_BUSY | M_MEM_RD, M_BUSY | M_MEM_RD | M_IMM_LD | M_PC_INC, f);
            if (f) return;
        end
        if (s[S_IN1]) begin
            model_wait(ow, 1'b1, M_BUSY | M_IN_EN, M_BUSY | M_IN_EN | M_REG_WE, f);
            return;
        end
        if (s[S_OUT1]) begin
            model_wait(ow, 1'b1, M_BUSY | M_OUT_EN, M_BUSY | M_OUT_EN, f);
            return;
        end
        e = M_BUSY;
        if (s[S_MOVA] || s[S_MOVB] || s[S_MOVC] || s[S_MOVD]) e = e | M_REG_WE;
        if (s[S_ADD]) e = e | M_REG_WE | M_FLAG_WE | M_ALU_ADD;
        if (s[S_SUB]) e = e | M_REG_WE | M_FLAG_WE | M_ALU_SUB;
        if (s[S_MOVI]) e = e | M_REG_WE | M_IMM_SEL;
        if (s[S_JMP] || (s[S_JG] && gt)) e = e | M_PC_LD;
        push(e, rb(), rb(), gt, 12'($urandom));
    endtask

    // One FETCH cycle with memory not yet ready, closing a trace.
    task automatic model_tail();
        if (!dead) push(M_BUSY | M_MEM_RD, 1'b0, rb(), rb(), 12'($urandom));
    endtask

    task automatic run_queue(input string name);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0) begin
            c       = q.pop_front();
            start   = c.start;
            mem_rdy = c.mem_rdy;
            io_ack  = c.io_ack;
            flag_gt = c.flag_gt;
            dec_op  = c.dec_op;
            @(negedge clk);
            checks++;
            if (obs() !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d outputs %h expected %h", name, n, obs(), c.exp);
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        start   = rb();
        mem_rdy = rb();
        io_ack  = rb();
        flag_gt = rb();
        dec_op  = 12'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        dead  = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start   = 1'b1;
            mem_rdy = rb();
            io_ack  = rb();
            dec_op  = 12'($urandom);
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (obs() !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold outputs %h expected 0000", obs());
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rdy = rb();
            io_ack  = rb();
            @(negedge clk);
            checks++;
            if (obs() !== 16'h0000) begin
                errors++;
                $display("FAIL idle_no_start outputs %h expected 0000", obs());
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_add();
        do_reset();
        push_start();
        model_instr(stb(S_ADD), 0, 0, 0, rb());
        model_tail();
        run_queue("add");
    endtask

    task automatic test_movi();
        do_reset();
        push_start();
        model_instr(stb(S_MOVI), 0, 2, 0, rb());
        model_tail();
        run_queue("movi");
    endtask

    task automatic test_jg();
        do_reset();
        push_start();
        model_instr(stb(S_JG), 0, 0, 0, 1'b0);
        model_instr(stb(S_JG), 1, 1, 0, 1'b1);
        model_instr(stb(S_JMP), 0, 0, 0, 1'b0);
        model_tail();
        run_queue("jg");
    endtask

    task automatic test_io();
        do_reset();
        push_start();
        model_instr(stb(S_IN1), 0, 0, 3, rb());
        model_instr(stb(S_OUT1), 0, 0, 2, rb());
        model_instr(stb(S_OUT1), 0, 0, 0, rb());
        model_tail();
        run_queue("io");
    endtask

    task automatic test_illegal();
        do_reset();
        push_start();
        model_instr(12'h000, 0, 0, 0, rb());
        run_queue("illegal_none");
        do_reset();
        push_start();
        model_instr(stb(S_ADD) | stb(S_SUB), 0, 0, 0, rb());
        run_queue("illegal_two");
    endtask

    task automatic test_wdog();
        // A handshake in the 16th wait cycle still completes.
        do_reset();
        push_start();
        model_instr(stb(S_MOVI), 15, 15, 0, rb());
        model_instr(stb(S_IN1), 0, 0, 15, rb());
        model_tail();
        run_queue("wdog_edge");
        do_reset();
        push_start();
        model_instr(stb(S_MOVA), 16, 0, 0, rb());
        run_queue("wdog_fetch");
        do_reset();
        push_start();
        model_instr(stb(S_OUT1), 0, 0, 20, rb());
        run_queue("wdog_io");
    endtask

    task automatic test_halt();
        do_reset();
        push_start();
        model_instr(stb(S_MOVB), 0, 0, 0, rb());
        model_instr(stb(S_HALT), 0, 0, 0, rb());
        run_queue("halt");
    endtask

    task automatic test_reset_mid_imm();
        do_reset();
        push_start();
        push(M_BUSY | M_MEM_RD | M_IR_LD | M_PC_INC, 1'b1, rb(), rb(), 12'($urandom));
        push(M_BUSY | M_DEC_EN, rb(), rb(), rb(), stb(S_MOVI));
        push(M_BUSY | M_MEM_RD, 1'b0, rb(), rb(), 12'($urandom));
        push(M_BUSY | M_MEM_RD, 1'b0, rb(), rb(), 12'($urandom));
        run_queue("rst_mid_imm");
        rst_n   = 1'b0;
        mem_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        start   = 1'b0;
        mem_rdy = 1'b1;
        io_ack  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 16'h0000) begin
                errors++;
                $display("FAIL rst_mid_imm_idle outputs %h expected 0000", obs());
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        do_reset();
        push_start();
        for (int i = 0; i < 30; i++) begin
            idx = $urandom_range(1, 11);
            model_instr(stb(idx), $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 4), rb());
        end
        model_instr(stb(S_HALT), $urandom_range(0, 3), 0, 0, rb());
        run_queue("back_to_back");
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        mem_rdy = 1'b0;
        io_ack  = 1'b0;
        flag_gt = 1'b0;
        dec_op  = 12'h000;
        dead    = 1'b0;
        test_reset();
        test_add();
        test_movi();
        test_jg();
        test_io();
        test_illegal();
        test_wdog();
        test_halt();
        test_reset_mid_imm();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
